// File: rtl/async_pkg.sv
// Shared definitions for the asynchronous dataflow operator nodes:
// operation codes, the OP-name decoder and a constant clog2 helper.
package async_pkg;

    localparam int OP_PASS = 0;
    localparam int OP_ADD  = 1;
    localparam int OP_SUB  = 2;
    localparam int OP_MUL  = 3;
    localparam int OP_AND  = 4;
    localparam int OP_OR   = 5;
    localparam int OP_XOR  = 6;
    localparam int OP_ADDI = 7;
    localparam int OP_SUBI = 8;
    localparam int OP_MULI = 9;

    // Map the OP name (up to 8 characters) to its code; reg/in/out and
    // anything unknown behave as a plain pass-through.
    function automatic int op_code(input logic [63:0] s);
        case (s)
            64'("add"):  return OP_ADD;
            64'("sub"):  return OP_SUB;
            64'("mul"):  return OP_MUL;
            64'("and"):  return OP_AND;
            64'("or"):   return OP_OR;
            64'("xor"):  return OP_XOR;
            64'("addi"): return OP_ADDI;
            64'("subi"): return OP_SUBI;
            64'("muli"): return OP_MULI;
            default:     return OP_PASS;
        endcase
    endfunction

    // Ceiling log2 for elaboration-time sizing.
    function automatic int clog2(input int v);
        int r;
        r = 0;
        while ((1 << r) < v) r = r + 1;
        return r;
    endfunction

endpackage

// File: rtl/dataflow_alu.sv
// Combinational operator of a dataflow node. All arithmetic is unsigned
// and wraps at DATA_WIDTH bits; sub is opnd0 minus the sum of the rest.
module dataflow_alu import async_pkg::*; #(
    parameter int                    INPUT_SIZE = 2,
    parameter int                    DATA_WIDTH = 32,
    parameter logic [63:0]           OP         = "add",
    parameter logic [DATA_WIDTH-1:0] IMMEDIATE  = '0
) (
    input  logic [INPUT_SIZE-1:0][DATA_WIDTH-1:0] opnd,
    output logic [DATA_WIDTH-1:0]                 result
);

    localparam int CODE = op_code(OP);

    // Fold the operands left to right starting from opnd0.
    always_comb begin
        result = opnd[0];
        case (CODE)
            OP_ADD:  for (int i = 1; i < INPUT_SIZE; i++) result = result + opnd[i];
            OP_SUB:  for (int i = 1; i < INPUT_SIZE; i++) result = result - opnd[i];
            OP_MUL:  for (int i = 1; i < INPUT_SIZE; i++) result = result * opnd[i];
            OP_AND:  for (int i = 1; i < INPUT_SIZE; i++) result = result & opnd[i];
            OP_OR:   for (int i = 1; i < INPUT_SIZE; i++) result = result | opnd[i];
            OP_XOR:  for (int i = 1; i < INPUT_SIZE; i++) result = result ^ opnd[i];
            OP_ADDI: result = opnd[0] + IMMEDIATE;
            OP_SUBI: result = opnd[0] - IMMEDIATE;
            OP_MULI: result = opnd[0] * IMMEDIATE;
            default: result = opnd[0];
        endcase
    end

endmodule

// File: rtl/async_operator_fifo.sv
// Dataflow operator node: gathers one operand per input channel, pushes
// f(operands) into a DEPTH-entry FIFO and forks each head entry to every
// consumer. The head pops once every consumer has taken it.
module async_operator_fifo import async_pkg::*; #(
    parameter int                    DATA_WIDTH  = 32,
    parameter int                    INPUT_SIZE  = 2,
    parameter int                    OUTPUT_SIZE = 2,
    parameter int                    DEPTH       = 4,
    parameter logic [63:0]           OP          = "add",
    parameter logic [DATA_WIDTH-1:0] IMMEDIATE   = '0,
    localparam int                   LW          = clog2(DEPTH) + 1
) (
    input  logic                              clk,
    input  logic                              rst,
    output logic [INPUT_SIZE-1:0]             req_l,
    input  logic [INPUT_SIZE-1:0]             ack_l,
    input  logic [INPUT_SIZE*DATA_WIDTH-1:0]  din,
    input  logic [OUTPUT_SIZE-1:0]            req_r,
    output logic [OUTPUT_SIZE-1:0]            ack_r,
    output logic [OUTPUT_SIZE*DATA_WIDTH-1:0] dout,
    output logic [LW-1:0]                     level
);

    localparam int AW = clog2(DEPTH);

    logic [INPUT_SIZE-1:0][DATA_WIDTH-1:0]  din_v;
    logic [INPUT_SIZE-1:0][DATA_WIDTH-1:0]  opnd;
    logic [OUTPUT_SIZE-1:0][DATA_WIDTH-1:0] dout_q;
    logic [DATA_WIDTH-1:0]                  mem [DEPTH];
    logic [AW-1:0]                          wr_ptr, rd_ptr;
    logic [INPUT_SIZE-1:0]                  has;
    logic [OUTPUT_SIZE-1:0]                 served, served_nxt, grant;
    logic                                   nonempty, pop, fire;
    logic [DATA_WIDTH-1:0]                  result;

    assign din_v = din;
    assign dout  = dout_q;

    dataflow_alu #(
        .INPUT_SIZE (INPUT_SIZE),
        .DATA_WIDTH (DATA_WIDTH),
        .OP         (OP),
        .IMMEDIATE  (IMMEDIATE)
    ) u_alu (
        .opnd   (opnd),
        .result (result)
    );

    // Handshake decisions: which consumers take the head, whether the head
    // pops, and whether a complete operand set can be pushed this cycle.
    always_comb begin
        nonempty   = (level != '0);
        grant      = {OUTPUT_SIZE{nonempty}} & ~served & req_r & ~ack_r;
        served_nxt = served | grant;
        pop        = nonempty && (&served_nxt);
        fire       = (&has) && ((level < LW'(DEPTH)) || pop);
    end

    // Per-input request/capture state; acks without an outstanding request are ignored.
    always_ff @(posedge clk) begin
        if (rst) begin
            req_l <= '0;
            has   <= '0;
        end else begin
            for (int i = 0; i < INPUT_SIZE; i++) begin
                if (fire) begin
                    has[i]   <= 1'b0;
                    req_l[i] <= 1'b1;
                end else if (req_l[i] && ack_l[i]) begin
                    has[i]   <= 1'b1;
                    req_l[i] <= 1'b0;
                end else if (!has[i] && !req_l[i]) begin
                    req_l[i] <= 1'b1;
                end
            end
        end
    end

    // Operand registers need no reset: has[] qualifies them.
    always_ff @(posedge clk) begin
        for (int i = 0; i < INPUT_SIZE; i++)
            if (req_l[i] && ack_l[i]) opnd[i] <= din_v[i];
    end

    // FIFO storage write; kept reset-free so it can map onto a RAM.
    always_ff @(posedge clk) begin
        if (fire && !rst) mem[wr_ptr] <= result;
    end

    // Pointers, occupancy and the served mask of the head entry.
    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            level  <= '0;
            served <= '0;
        end else begin
            if (fire) wr_ptr <= wr_ptr + 1'b1;
            if (pop)  rd_ptr <= rd_ptr + 1'b1;
            served <= pop ? '0 : served_nxt;
            case ({fire, pop})
                2'b10:   level <= level + 1'b1;
                2'b01:   level <= level - 1'b1;
                default: level <= level;
            endcase
        end
    end

    // Per-consumer ack pulse and registered copy of the head.
    always_ff @(posedge clk) begin
        if (rst) begin
            ack_r  <= '0;
            dout_q <= '0;
        end else begin
            ack_r <= grant;
            for (int j = 0; j < OUTPUT_SIZE; j++)
                if (grant[j]) dout_q[j] <= mem[rd_ptr];
        end
    end

endmodule

// File: tb/tb_async_operator_fifo.sv
// Bench for async_operator_fifo: randomized upstream/downstream handshakes
// against an operand-list scoreboard, plus 8-bit wrap/truncation nodes.
module tb_async_operator_fifo;

    localparam int DW  = 32;
    localparam int IS  = 2;
    localparam int OS  = 2;
    localparam int DEP = 4;
    localparam int LW  = 3;
    localparam int MAXN = 1024;

    logic              clk = 1'b0;
    logic              rst = 1'b1;
    logic [IS-1:0]     req_l;
    logic [IS-1:0]     ack_l;
    logic [IS*DW-1:0]  din;
    logic [OS-1:0]     req_r;
    logic [OS-1:0]     ack_r;
    logic [OS*DW-1:0]  dout;
    logic [LW-1:0]     level;

    always #5 clk = ~clk;

    async_operator_fifo #(
        .DATA_WIDTH(DW), .INPUT_SIZE(IS), .OUTPUT_SIZE(OS), .DEPTH(DEP), .OP("add"), .IMMEDIATE(32'd0)
    ) dut (
        .clk(clk), .rst(rst), .req_l(req_l), .ack_l(ack_l), .din(din),
        .req_r(req_r), .ack_r(ack_r), .dout(dout), .level(level)
    );

    // 8-bit nodes whose upstream acks every request with constant operands.
    logic [1:0]  rl_s, rl_m, rl_a;
    logic [15:0] din_s = {8'd5, 8'd3};
    logic [15:0] din_m = {8'd20, 8'd20};
    logic [15:0] din_a = {8'd0, 8'd255};
    logic        one = 1'b1;
    logic        ar_s, ar_m, ar_a;
    logic [7:0]  do_s, do_m, do_a;
    logic [1:0]  lv_s, lv_m, lv_a;

    async_operator_fifo #(.DATA_WIDTH(8), .INPUT_SIZE(2), .OUTPUT_SIZE(1), .DEPTH(2), .OP("sub"), .IMMEDIATE(8'd0))
    dut_sub (.clk(clk), .rst(rst), .req_l(rl_s), .ack_l(rl_s), .din(din_s),
             .req_r(one), .ack_r(ar_s), .dout(do_s), .level(lv_s));
    async_operator_fifo #(.DATA_WIDTH(8), .INPUT_SIZE(2), .OUTPUT_SIZE(1), .DEPTH(2), .OP("mul"), .IMMEDIATE(8'd0))
    dut_mul (.clk(clk), .rst(rst), .req_l(rl_m), .ack_l(rl_m), .din(din_m),
             .req_r(one), .ack_r(ar_m), .dout(do_m), .level(lv_m));
    async_operator_fifo #(.DATA_WIDTH(8), .INPUT_SIZE(2), .OUTPUT_SIZE(1), .DEPTH(2), .OP("addi"), .IMMEDIATE(8'd2))
    dut_addi (.clk(clk), .rst(rst), .req_l(rl_a), .ack_l(rl_a), .din(din_a),
              .req_r(one), .ack_r(ar_a), .dout(do_a), .level(lv_a));

    int n_err = 0;
    int n_chk = 0;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] want);
        n_chk++;
        if (obs !== want) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, want, $time);
        end
    endtask

    // Scoreboard: operand k of every input, and the result the node must deliver.
    logic [DW-1:0] ops [IS][MAXN];
    int            n_ops = 0;
    int            sent [IS];
    int            got  [OS];
    logic [OS-1:0] prev_ack = '0;
    logic [IS-1:0] up_en = '0;
    logic [OS-1:0] cons_en = '0;
    int            ack_pct = 100;
    int            req_pct = 100;
    bit            burst = 1'b0;
    bit            force_hi = 1'b0;
    int            full_cnt = 0;

    function automatic logic [DW-1:0] ref_f(input int k);
        return ops[0][k] + ops[1][k];
    endfunction

    // Monitor outputs, then drive upstream acks and downstream requests.
    initial begin
        ack_l = '0; req_r = '0; din = '0;
        forever begin
            @(negedge clk);
            if (!rst) begin
                if (level == LW'(DEP)) full_cnt++;
                for (int j = 0; j < OS; j++) begin
                    if (ack_r[j]) begin
                        chk("ack_gap", {63'd0, prev_ack[j]}, 64'd0);
                        chk("level_le_depth", {63'd0, (level <= LW'(DEP))}, 64'd1);
                        if (got[j] < n_ops) chk($sformatf("dout%0d[%0d]", j, got[j]), dout[j*DW +: DW], ref_f(got[j]));
                        else chk($sformatf("extra_ack%0d", j), 64'd1, 64'd0);
                        got[j]++;
                    end
                end
            end
            prev_ack = ack_r;
            if (force_hi) begin
                ack_l = '1;
                req_r = '1;
            end else begin
                if (burst && $urandom_range(31) == 0) req_pct = ($urandom_range(1) == 1) ? 15 : 95;
                for (int i = 0; i < IS; i++) begin
                    ack_l[i] = 1'b0;
                    if (!rst && up_en[i] && req_l[i] && sent[i] < n_ops && $urandom_range(99) < ack_pct) begin
                        ack_l[i] = 1'b1;
                        din[i*DW +: DW] = ops[i][sent[i]];
                        sent[i]++;
                    end
                end
                for (int j = 0; j < OS; j++)
                    req_r[j] = cons_en[j] && ($urandom_range(99) < req_pct);
            end
        end
    end

    // Reset the DUTs, load n fresh random operand sets and clear the scoreboard.
    task automatic start_phase(input int n);
        rst = 1'b1;
        up_en = '0;
        cons_en = '0;
        for (int k = 0; k < MAXN; k++) begin
            ops[0][k] = $urandom;
            ops[1][k] = $urandom;
        end
        for (int i = 0; i < IS; i++) sent[i] = 0;
        for (int j = 0; j < OS; j++) got[j] = 0;
        full_cnt = 0;
        n_ops = n;
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
    endtask

    task automatic wait_got(input int n, input int limit, input string tag);
        int t;
        t = 0;
        while ((got[0] < n || got[1] < n) && t < limit) begin
            @(posedge clk); #1;
            t++;
        end
        chk(tag, {63'd0, (got[0] >= n && got[1] >= n)}, 64'd1);
    endtask

    initial begin
        int t;
        // Reset with handshake inputs held high.
        @(posedge clk); #1;
        force_hi = 1'b1;
        rst = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_req_l", req_l, 0);
        chk("rst_ack_r", ack_r, 0);
        chk("rst_dout", dout, 0);
        chk("rst_level", level, 0);
        force_hi = 1'b0;
        @(negedge clk); #1;
        rst = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        chk("rst_req_l_rise", req_l, 2'b11);
        chk("rst_no_ack", ack_r, 0);

        // Single add: 5 + 7 to both consumers.
        start_phase(1);
        ops[0][0] = 32'd5;
        ops[1][0] = 32'd7;
        ack_pct = 100; req_pct = 100;
        up_en = '1; cons_en = '1;
        wait_got(1, 50, "add_done");
        repeat (3) @(posedge clk);
        #1;
        chk("add_got0", got[0], 1);
        chk("add_got1", got[1], 1);
        chk("add_level", level, 0);

        // Fork with consumer 1 stalled: consumer 0 takes only the head, since
        // the head cannot pop until every consumer has it; the FIFO fills.
        start_phase(6);
        up_en = '1; cons_en = 2'b01;
        repeat (80) @(posedge clk);
        #1;
        chk("fork_got0", got[0], 1);
        chk("fork_got1", got[1], 0);
        chk("fork_level", level, DEP);
        chk("fork_req_l", req_l, 0);
        chk("fork_sent", sent[0] + sent[1], 10);
        cons_en = '1;
        wait_got(6, 200, "fork_drain");
        repeat (3) @(posedge clk);
        #1;
        chk("fork_got0_all", got[0], 6);
        chk("fork_got1_all", got[1], 6);
        chk("fork_level_end", level, 0);

        // Long random run with bursty consumers so the FIFO hits full often.
        start_phase(1000);
        ack_pct = 70; req_pct = 50; burst = 1'b1;
        up_en = '1; cons_en = '1;
        wait_got(1000, 40000, "rand_done");
        burst = 1'b0; req_pct = 100;
        repeat (4) @(posedge clk);
        #1;
        chk("rand_got0", got[0], 1000);
        chk("rand_got1", got[1], 1000);
        chk("rand_level", level, 0);
        chk("rand_full_seen", {63'd0, (full_cnt > 0)}, 64'd1);

        // Reset mid-stream with three queued results and input 0 captured.
        start_phase(20);
        ack_pct = 100;
        up_en = '1; cons_en = '0;
        t = 0;
        while (level != 3 && t < 100) begin
            @(posedge clk); #1;
            t++;
        end
        chk("mid_level3", level, 3);
        up_en = 2'b01;
        @(posedge clk); #1;
        chk("mid_has01", sent[0] - sent[1], 1);
        start_phase(5);
        @(posedge clk); #1;
        chk("mid_level0", level, 0);
        chk("mid_ack0", ack_r, 0);
        up_en = '1; cons_en = '1;
        wait_got(5, 100, "mid_done");

        // 8-bit wrap/truncation nodes have been streaming since the last reset.
        chk("sub8_3m5", do_s, 8'd254);
        chk("mul8_20x20", do_m, 8'd144);
        chk("addi8_255p2", do_a, 8'd1);

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule
